// File: rtl/data_mem_lsu.sv
// Byte-addressed data RAM behind a RISC-V load/store port; 1-cycle registered response, 2 cycles for split misaligned beats.
// req_ready drops only during the second beat of a split access; responses have no backpressure.
module data_mem_lsu #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH            = 1024,
  parameter int SPLIT_MISALIGNED = 1,
  parameter int DISPLAY_EN       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [31:0]           req_pc,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IW    = $clog2(DEPTH);
  localparam bit SPLIT = (SPLIT_MISALIGNED != 0);

  typedef enum logic {IDLE, BEAT2} state_e;

  state_e                  state_q, state_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_err_q, resp_err_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    lat_write_q, lat_write_d;
  logic [2:0]              lat_f3_q, lat_f3_d;
  logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
  logic [31:0]             lat_wdata_q, lat_wdata_d;
  logic [31:0]             lat_pc_q, lat_pc_d;
  logic [31:0]             lo_q, lo_d;

  logic [31:0] mem_q [DEPTH];

  logic                  beat2, accept;
  logic                  cur_write;
  logic [2:0]            cur_f3;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_wdata, cur_pc;
  logic [3:0]            smask, wr_mask;
  logic [7:0]            m8;
  logic [63:0]           wd64, src64;
  logic [31:0]           wr_data, rd_word, merged, raw, ext;
  logic [ADDR_WIDTH-3:0] wword;
  logic [IW-1:0]         wr_idx;
  logic                  crossing, illegal, err, wr_en;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready && !rst;
  assign beat2     = (state_q == BEAT2);

  // Beat 2 replays the latched request; the live inputs are only looked at in IDLE.
  assign cur_write = beat2 ? lat_write_q : req_write;
  assign cur_f3    = beat2 ? lat_f3_q    : req_funct3;
  assign cur_addr  = beat2 ? lat_addr_q  : req_addr;
  assign cur_wdata = beat2 ? lat_wdata_q : req_wdata;
  assign cur_pc    = beat2 ? lat_pc_q    : req_pc;

  always_comb begin
    smask = 4'b1111;
    case (cur_f3[1:0])
      2'd0:    smask = 4'b0001;
      2'd1:    smask = 4'b0011;
      default: smask = 4'b1111;
    endcase
  end

  // Lanes/data above bit 31 of the shifted views belong to the next word.
  assign m8       = {4'b0000, smask} << cur_addr[1:0];
  assign wd64     = {32'h0, cur_wdata} << {cur_addr[1:0], 3'b000};
  assign crossing = |m8[7:4];
  assign illegal  = (cur_f3 == 3'd3) || (cur_f3 == 3'd6) || (cur_f3 == 3'd7) ||
                    (cur_write && cur_f3[2]);
  assign err      = illegal || (crossing && !SPLIT);

  assign wr_mask = beat2 ? m8[7:4] : m8[3:0];
  assign wr_data = beat2 ? wd64[63:32] : wd64[31:0];
  assign wword   = cur_addr[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(beat2);
  assign wr_idx  = wword[IW-1:0];
  assign rd_word = mem_q[wr_idx];
  assign wr_en   = !rst && (beat2 || accept) && cur_write && !err;

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (wr_mask[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  assign src64 = beat2 ? {rd_word, lo_q} : {32'h0, rd_word};
  assign raw   = 32'(src64 >> {cur_addr[1:0], 3'b000});

  always_comb begin
    ext = raw;
    case (cur_f3)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ext = {24'h0, raw[7:0]};
      3'd5:    ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    lat_write_d  = lat_write_q;
    lat_f3_d     = lat_f3_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_pc_d     = lat_pc_q;
    lo_d         = lo_q;
    if (beat2) begin
      state_d      = IDLE;
      resp_valid_d = 1'b1;
      resp_rdata_d = lat_write_q ? 32'h0 : ext;
    end else if (accept) begin
      if (crossing && !err) begin
        state_d     = BEAT2;
        lat_write_d = req_write;
        lat_f3_d    = req_funct3;
        lat_addr_d  = req_addr;
        lat_wdata_d = req_wdata;
        lat_pc_d    = req_pc;
        lo_d        = rd_word;
      end else begin
        resp_valid_d = 1'b1;
        resp_err_d   = err;
        resp_rdata_d = (cur_write || err) ? 32'h0 : ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      lat_write_q  <= 1'b0;
      lat_f3_q     <= 3'd0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= 32'h0;
      lat_pc_q     <= 32'h0;
      lo_q         <= 32'h0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      lat_write_q  <= lat_write_d;
      lat_f3_q     <= lat_f3_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_pc_q     <= lat_pc_d;
      lo_q         <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= merged;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (DISPLAY_EN != 0 && wr_en)
      $display("pc = %h: dataaddr = %h, memdata = %h", cur_pc, {wword, 2'b00}, merged);
  end
`endif

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one split-mode and one error-mode instance sharing request fields.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_s = 1'b0, vld_n = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = 32'h0, wd = 32'h0, pc = 32'h0;
  logic        rdy_s, rv_s, re_s, rdy_n, rv_n, re_n;
  logic [31:0] rd_s, rd_n;
  logic [31:0] vals [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH(1024), .SPLIT_MISALIGNED(1), .DISPLAY_EN(1)) u_split (
    .clk(clk), .rst(rst), .req_valid(vld_s), .req_ready(rdy_s), .req_write(wr),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wd), .req_pc(pc),
    .resp_valid(rv_s), .resp_rdata(rd_s), .resp_err(re_s));

  data_mem_lsu #(.ADDR_WIDTH(32), .DEPTH(1024), .SPLIT_MISALIGNED(0), .DISPLAY_EN(0)) u_nosplit (
    .clk(clk), .rst(rst), .req_valid(vld_n), .req_ready(rdy_n), .req_write(wr),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wd), .req_pc(pc),
    .resp_valid(rv_n), .resp_rdata(rd_n), .resp_err(re_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle request; returns at the falling edge right after the accepting edge.
  task automatic issue(input bit ns, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; f3 = f; addr = a; wd = d; pc = pc + 32'd4;
    if (ns) vld_n = 1'b1; else vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0; vld_n = 1'b0;
  endtask

  task automatic resp_chk(input bit ns, input string tag, input logic e, input logic [31:0] exp);
    chk({tag, " vld"},  32'(ns ? rv_n : rv_s), 32'd1);
    chk({tag, " err"},  32'(ns ? re_n : re_s), 32'(e));
    chk({tag, " data"}, ns ? rd_n : rd_s, exp);
  endtask

  task automatic st(input bit ns, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] d, input string tag);
    issue(ns, 1'b1, f, a, d);
    resp_chk(ns, tag, 1'b0, 32'h0);
  endtask

  task automatic ld(input bit ns, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] exp, input string tag);
    issue(ns, 1'b0, f, a, 32'h0);
    resp_chk(ns, tag, 1'b0, exp);
  endtask

  task automatic bad(input bit ns, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    issue(ns, w, f, a, d);
    resp_chk(ns, tag, 1'b1, 32'h0);
  endtask

  task automatic split_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string tag);
    issue(1'b0, w, f, a, d);
    chk({tag, " rdy_beat2"}, 32'(rdy_s), 32'd0);
    chk({tag, " vld_n1"},    32'(rv_s),  32'd0);
    @(negedge clk);
    resp_chk(1'b0, tag, 1'b0, exp);
    chk({tag, " rdy_after"}, 32'(rdy_s), 32'd1);
  endtask

  initial begin
    #1;
    chk("rst vld_s", 32'(rv_s), 32'd0);
    chk("rst err_s", 32'(re_s), 32'd0);
    chk("rst data_s", rd_s, 32'h0);
    chk("rst rdy_s", 32'(rdy_s), 32'd1);
    chk("rst vld_n", 32'(rv_n), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned word store/load and pulse width
    st(1'b0, 3'd2, 32'h10, 32'h11223344, "sw10");
    ld(1'b0, 3'd2, 32'h10, 32'h11223344, "lw10");
    @(negedge clk);
    chk("vld pulse clears", 32'(rv_s), 32'd0);

    // Byte/half lanes and extension
    st(1'b0, 3'd0, 32'h11, 32'h00000080, "sb11");
    ld(1'b0, 3'd0, 32'h11, 32'hFFFFFF80, "lb11");
    ld(1'b0, 3'd4, 32'h11, 32'h00000080, "lbu11");
    ld(1'b0, 3'd2, 32'h10, 32'h11228044, "lw10b");
    ld(1'b0, 3'd1, 32'h11, 32'h00002280, "lh11");
    ld(1'b0, 3'd5, 32'h12, 32'h00001122, "lhu12");
    st(1'b0, 3'd1, 32'h12, 32'h1234BEEF, "sh12");
    ld(1'b0, 3'd2, 32'h10, 32'hBEEF8044, "lw10c");
    ld(1'b0, 3'd1, 32'h12, 32'hFFFFBEEF, "lh12");

    // Store immediately followed by load of the same word
    @(negedge clk);
    wr = 1'b1; f3 = 3'd2; addr = 32'h30; wd = 32'h00000077; vld_s = 1'b1;
    @(negedge clk);
    wr = 1'b0; addr = 32'h30;
    resp_chk(1'b0, "b2b sw", 1'b0, 32'h0);
    @(negedge clk);
    vld_s = 1'b0;
    resp_chk(1'b0, "b2b lw", 1'b0, 32'h00000077);

    // Split word store/load across 0x20/0x24
    st(1'b0, 3'd2, 32'h20, 32'h0, "clr20");
    st(1'b0, 3'd2, 32'h24, 32'h0, "clr24");
    split_op(1'b1, 3'd2, 32'h22, 32'hAABBCCDD, 32'h0, "sw22");
    ld(1'b0, 3'd2, 32'h20, 32'hCCDD0000, "lw20");
    ld(1'b0, 3'd2, 32'h24, 32'h0000AABB, "lw24");
    split_op(1'b0, 3'd2, 32'h22, 32'h0, 32'hAABBCCDD, "lw22");
    split_op(1'b0, 3'd1, 32'h23, 32'h0, 32'hFFFFBBCC, "lh23");
    split_op(1'b0, 3'd5, 32'h23, 32'h0, 32'h0000BBCC, "lhu23");

    // Inputs changed during beat 2 must be ignored
    @(negedge clk);
    wr = 1'b0; f3 = 3'd2; addr = 32'h22; vld_s = 1'b1;
    @(negedge clk);
    wr = 1'b1; addr = 32'h20; wd = 32'hFFFFFFFF;
    chk("hold rdy", 32'(rdy_s), 32'd0);
    @(negedge clk);
    vld_s = 1'b0;
    resp_chk(1'b0, "hold lw22", 1'b0, 32'hAABBCCDD);
    ld(1'b0, 3'd2, 32'h20, 32'hCCDD0000, "hold lw20");

    // Illegal funct3 on the split instance
    bad(1'b0, 1'b1, 3'd5, 32'h40, 32'h1, "sthu");
    bad(1'b0, 1'b0, 3'd3, 32'h40, 32'h0, "ld f3=3");

    // Error mode for crossing accesses
    st(1'b1, 3'd2, 32'h04, 32'hCAFEF00D, "ns sw04");
    st(1'b1, 3'd2, 32'h08, 32'h0BADBEEF, "ns sw08");
    bad(1'b1, 1'b0, 3'd1, 32'h07, 32'h0, "ns lh07");
    bad(1'b1, 1'b1, 3'd2, 32'h05, 32'h12345678, "ns sw05");
    bad(1'b1, 1'b1, 3'd4, 32'h04, 32'h99999999, "ns sbu04");
    ld(1'b1, 3'd2, 32'h04, 32'hCAFEF00D, "ns lw04");
    ld(1'b1, 3'd2, 32'h08, 32'h0BADBEEF, "ns lw08");
    ld(1'b1, 3'd1, 32'h05, 32'hFFFFFEF0, "ns lh05");

    // Wrap from the last word to word 0
    st(1'b0, 3'd2, 32'h0, 32'h0, "clr0");
    st(1'b0, 3'd2, 32'hFFC, 32'h0, "clrFFC");
    split_op(1'b1, 3'd2, 32'hFFE, 32'h01020304, 32'h0, "swFFE");
    ld(1'b0, 3'd2, 32'hFFC, 32'h03040000, "lwFFC");
    ld(1'b0, 3'd2, 32'h0, 32'h00000102, "lw0");
    split_op(1'b0, 3'd2, 32'hFFE, 32'h0, 32'h01020304, "lwFFE");

    // Reset during beat 2: beat 1 persists, beat 2 dropped, no response
    issue(1'b0, 1'b1, 3'd2, 32'hFFE, 32'hA5A5A5A5);
    rst = 1'b1;
    #1;
    chk("rstb2 vld", 32'(rv_s), 32'd0);
    chk("rstb2 rdy", 32'(rdy_s), 32'd1);
    @(negedge clk);
    chk("rstb2 vld later", 32'(rv_s), 32'd0);
    rst = 1'b0;
    ld(1'b0, 3'd2, 32'h0, 32'h00000102, "rstb2 lw0");
    ld(1'b0, 3'd2, 32'hFFC, 32'hA5A50000, "rstb2 lwFFC");

    // Reset while a response is showing
    issue(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("rstresp pre", 32'(rv_s), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstresp vld", 32'(rv_s), 32'd0);
    chk("rstresp data", rd_s, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back aligned loads
    for (int i = 0; i < 8; i++) begin
      vals[i] = 32'h11111111 * 32'(i) + 32'h01000001;
      st(1'b0, 3'd2, 32'h40 + 32'(4 * i), vals[i], "fill");
    end
    @(negedge clk);
    wr = 1'b0; f3 = 3'd2; addr = 32'h40; vld_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 7) addr = 32'h40 + 32'(4 * (i + 1));
      else vld_s = 1'b0;
      chk("burst vld", 32'(rv_s), 32'd1);
      chk("burst rdy", 32'(rdy_s), 32'd1);
      chk("burst data", rd_s, vals[i]);
    end
    @(negedge clk);
    chk("burst end", 32'(rv_s), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
